// File: rtl/minesweeper_pkg.sv
// Shared constants and types for the minesweeper board logic.
// Board geometry, mine count and the placer state encoding live here.
package minesweeper_pkg;
  localparam int ROWS   = 9;
  localparam int COLS   = 9;
  localparam int CELLS  = ROWS * COLS;
  localparam int MINES  = 9;
  localparam int IDX_W  = 8;
  localparam int CELL_W = $clog2(CELLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } placer_state_e;
endpackage

// File: rtl/mine_neighbour_count.sv
// Combinational count of mines in the 8 cells surrounding (row, col).
// Edges are clipped, never wrapped; the centre cell is not counted.
module mine_neighbour_count
  import minesweeper_pkg::*;
(
  input  logic [CELLS-1:0] board,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  output logic [3:0]       adj
);

  always_comb begin
    adj = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) &&
            (int'(row) + dr) >= 0 && (int'(row) + dr) < ROWS &&
            (int'(col) + dc) >= 0 && (int'(col) + dc) < COLS) begin
          if (board[CELL_W'((int'(row) + dr) * COLS + int'(col) + dc)]) begin
            adj = adj + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Consumes candidate indices, keeps the first MINES unique in-range ones as
// mines on the board bitmap, and serves a registered cell query port.
module mine_placer
  import minesweeper_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             idx_req,
  input  logic             idx_valid,
  input  logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] mines_placed,
  output logic [7:0]       reject_count,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_mine,
  output logic [3:0]       rd_adj
);

  localparam logic [IDX_W-1:0] CELLS_IDX = IDX_W'(CELLS);
  localparam logic [IDX_W-1:0] MINES_IDX = IDX_W'(MINES);
  localparam logic [IDX_W-1:0] COLS_IDX  = IDX_W'(COLS);

  placer_state_e    state_reg, state_next;
  logic [CELLS-1:0] board_reg;
  logic [IDX_W-1:0] mines_placed_reg;
  logic [7:0]       reject_count_reg;
  logic             rd_mine_reg;
  logic [3:0]       rd_adj_reg;

  logic             cand_in_range, cand_dup, consume, accept, reject, clear;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_row, rd_col;
  logic [3:0]       nb_adj;

  assign cand_in_range = idx < CELLS_IDX;
  assign cand_dup      = cand_in_range && board_reg[CELL_W'(idx)];
  assign consume       = (state_reg == REQ) && idx_valid;
  assign accept        = consume && cand_in_range && !cand_dup;
  assign reject        = consume && !accept;
  assign clear         = (state_reg == IDLE || state_reg == DONE) && start;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = REQ;
      REQ:        if (accept && (mines_placed_reg + IDX_W'(1)) == MINES_IDX) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      board_reg        <= '0;
      mines_placed_reg <= '0;
      reject_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        board_reg        <= '0;
        mines_placed_reg <= '0;
        reject_count_reg <= '0;
      end else begin
        if (accept) begin
          board_reg[CELL_W'(idx)] <= 1'b1;
          mines_placed_reg        <= mines_placed_reg + IDX_W'(1);
        end
        // Saturate so long unlucky runs do not wrap back to small values
        if (reject && reject_count_reg != 8'hFF) begin
          reject_count_reg <= reject_count_reg + 8'd1;
        end
      end
    end
  end

  assign rd_in_range = rd_idx < CELLS_IDX;
  assign rd_row      = rd_idx / COLS_IDX;
  assign rd_col      = rd_idx % COLS_IDX;

  mine_neighbour_count u_nb (
    .board (board_reg),
    .row   (rd_row),
    .col   (rd_col),
    .adj   (nb_adj)
  );

  // Query sees the board before any update landing on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_mine_reg <= 1'b0;
      rd_adj_reg  <= 4'd0;
    end else begin
      rd_mine_reg <= rd_in_range && board_reg[CELL_W'(rd_idx)];
      rd_adj_reg  <= rd_in_range ? nb_adj : 4'd0;
    end
  end

  assign idx_req      = (state_reg == REQ);
  assign busy         = (state_reg == REQ);
  assign done         = (state_reg == DONE);
  assign mines_placed = mines_placed_reg;
  assign reject_count = reject_count_reg;
  assign rd_mine      = rd_mine_reg;
  assign rd_adj       = rd_adj_reg;

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer: directed scenarios plus random games
// checked against a cell-level board model.
module tb_mine_placer;
  import minesweeper_pkg::*;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_DONE = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             idx_valid = 1'b0;
  logic [IDX_W-1:0] idx = '0;
  logic [IDX_W-1:0] rd_idx = '0;
  logic             idx_req, busy, done, rd_mine;
  logic [IDX_W-1:0] mines_placed;
  logic [7:0]       reject_count;
  logic [3:0]       rd_adj;

  mine_placer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .idx_req      (idx_req),
    .idx_valid    (idx_valid),
    .idx          (idx),
    .busy         (busy),
    .done         (done),
    .mines_placed (mines_placed),
    .reject_count (reject_count),
    .rd_idx       (rd_idx),
    .rd_mine      (rd_mine),
    .rd_adj       (rd_adj)
  );

  always #5 clock = ~clock;

  typedef struct { int qi; int mine; int adj; } q_exp_t;
  typedef struct { int st; int placed; int rej; } s_exp_t;

  q_exp_t qq[$];
  s_exp_t sq[$];
  int     n_checks = 0;
  int     n_fail = 0;
  bit     q_strobe = 1'b0;
  bit     q_d = 1'b0;

  bit     mboard[CELLS];
  int     mplaced = 0;
  int     mrej = 0;
  int     mstate = M_IDLE;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic q_exp_t ref_query(input int qi);
    q_exp_t e;
    int r, c;
    e.qi = qi; e.mine = 0; e.adj = 0;
    if (qi < CELLS) begin
      r = qi / COLS;
      c = qi % COLS;
      e.mine = mboard[qi] ? 1 : 0;
      for (int nr = r - 1; nr <= r + 1; nr++)
        for (int nc = c - 1; nc <= c + 1; nc++)
          if (!(nr == r && nc == c) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS)
            e.adj += mboard[nr * COLS + nc] ? 1 : 0;
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) mboard[i] = 1'b0;
    mplaced = 0;
    mrej = 0;
  endtask

  task automatic model_apply(input bit v, input int cand, input bit st);
    if (mstate != M_REQ) begin
      if (st) begin
        model_clear();
        mstate = M_REQ;
      end
    end else if (v) begin
      if (cand >= CELLS || mboard[cand]) begin
        if (mrej < 255) mrej++;
      end else begin
        mboard[cand] = 1'b1;
        mplaced++;
        if (mplaced == MINES) mstate = M_DONE;
      end
    end
  endtask

  // Called at posedge+1; drives one cycle and queues the expectations.
  task automatic step(input bit v, input int cand, input bit st,
                      input bit q, input int qi, input bit chk);
    idx_valid = v;
    idx       = IDX_W'(cand);
    start     = st;
    rd_idx    = IDX_W'(qi);
    q_strobe  = q;
    if (q) qq.push_back(ref_query(qi));
    model_apply(v, cand, st);
    @(posedge clock);
    #1;
    idx_valid = 1'b0;
    start     = 1'b0;
    q_strobe  = 1'b0;
    if (chk) sq.push_back('{st: mstate, placed: mplaced, rej: mrej});
  endtask

  task automatic feed(input int cand);    step(1'b1, cand, 1'b0, 1'b0, 0, 1'b1); endtask
  task automatic do_start();              step(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);    endtask
  task automatic query(input int qi);     step(1'b0, 0, 1'b0, 1'b1, qi, 1'b1);  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idx_req"}, idx_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mines_placed"}, mines_placed, 0);
    check({tag, "_reject_count"}, reject_count, 0);
    check({tag, "_rd_mine"}, rd_mine, 0);
    check({tag, "_rd_adj"}, rd_adj, 0);
  endtask

  always @(posedge clock) q_d <= q_strobe;

  always @(negedge clock) begin
    q_exp_t e;
    s_exp_t s;
    if (q_d) begin
      if (qq.size() == 0) begin
        check("query_queue_empty", 1, 0);
      end else begin
        e = qq.pop_front();
        $display("query  rd_idx=%0d mine=%0d/%0d adj=%0d/%0d", e.qi, rd_mine, e.mine, rd_adj, e.adj);
        check("rd_mine", rd_mine, e.mine);
        check("rd_adj", rd_adj, e.adj);
      end
    end
    if (sq.size() > 0) begin
      s = sq.pop_front();
      $display("status placed=%0d/%0d rej=%0d/%0d req=%0d done=%0d", mines_placed, s.placed,
               reject_count, s.rej, idx_req, done);
      check("idx_req", idx_req, (s.st == M_REQ) ? 1 : 0);
      check("busy", busy, (s.st == M_REQ) ? 1 : 0);
      check("done", done, (s.st == M_DONE) ? 1 : 0);
      check("mines_placed", mines_placed, s.placed);
      check("reject_count", reject_count, s.rej);
    end
  end

  task automatic async_reset_pulse(input string tag);
    sq.delete();
    #2 reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_clear();
    mstate = M_IDLE;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  int plan_cells[9] = '{0, 1, 9, 10, 18, 27, 36, 45, 54};
  int plan_q[6]     = '{0, 11, 19, 17, 80, 81};

  initial begin
    model_clear();
    #1 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Sequential indices fill the board with no rejects
    do_start();
    for (int i = 0; i < 9; i++) feed(i);
    query(8);
    query(9);

    // Duplicates, then a start pulse in REQ that must be ignored
    do_start();
    feed(5); feed(5); feed(5); feed(7);
    query(5); query(7); query(6); query(4);
    do_start();

    async_reset_pulse("rst_a");
    do_start();
    feed(81); feed(200);
    for (int i = 0; i < 9; i++) feed(plan_cells[i]);
    for (int i = 0; i < 6; i++) query(plan_q[i]);

    // Start from DONE clears the board
    do_start();
    query(0);
    feed(40); feed(41); feed(49); feed(31);
    async_reset_pulse("rst_mid");
    query(40);
    do_start();
    feed(0);
    query(41);

    // Reject counter saturation
    for (int i = 0; i < 260; i++) feed($urandom_range(81, 255));
    feed(3);

    // Random games, including idx_valid while idx_req is low
    for (int i = 0; i < 1500; i++) begin
      bit v, st, q;
      int cand, qi;
      v    = ($urandom_range(0, 3) != 0);
      cand = ($urandom_range(0, 4) == 0) ? int'($urandom_range(81, 255)) : int'($urandom_range(0, 80));
      st   = (mstate != M_REQ) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      q    = ($urandom_range(0, 1) == 1);
      qi   = $urandom_range(0, 90);
      step(v, cand, st, q, qi, 1'b1);
    end

    repeat (3) @(posedge clock);
    #1;
    check("queues_drained", qq.size() + sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
Consumer end of the random mine-index stream. The LFSR index generator produces candidate cell indices. This block requests indices, rejects out-of-range and duplicate ones, and records accepted mines in a ROWS x COLS board bitmap until MINES unique mines are placed. It sits between the generator and the game/display logic, and serves a registered cell-query port returning the mine flag and adjacent-mine count.

Parameters:
ROWS, 9, board rows
COLS, 9, board columns
MINES, 9, unique mines to place per game (1..ROWS*COLS)
IDX_W, 8, width of cell index (must hold ROWS*COLS-1)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin new placement (pulse, sampled in IDLE/DONE only)
idx_req  out  1  request for next candidate index
idx_valid  in  1  candidate present on idx this cycle
idx  in  IDX_W  candidate cell index
busy  out  1  placement in progress
done  out  1  MINES unique mines placed; held until next start/reset
mines_placed  out  IDX_W  accepted mine count
reject_count  out  8  rejected candidates this game, saturating at 255
rd_idx  in  IDX_W  query cell index
rd_mine  out  1  mine flag of rd_idx (registered)
rd_adj  out  4  mines among 8 neighbours of rd_idx (registered)

Behaviour:
- Reset (async, reset=0): state IDLE, board=0, mines_placed=0, reject_count=0, idx_req=0, busy=0, done=0, rd_mine=0, rd_adj=0. Applies immediately, mid-placement included.
- States: IDLE, REQ, DONE.
- IDLE: start=1 -> clear board and counters, go to REQ.
- REQ: idx_req=1, busy=1. On clock edge with idx_valid=1 the candidate is consumed in that same cycle.
  - If idx >= ROWS*COLS: reject.
  - Else if board[idx]=1: reject as duplicate.
  - Else: set board[idx] and increment mines_placed.
  - Reject increments reject_count, saturating at 255.
  - When the accept brings mines_placed to MINES: go to DONE on that edge; idx_req=0 next cycle.
  - idx_valid while idx_req=0 is ignored. start in REQ is ignored.
- DONE: done=1, busy=0, board frozen. start=1 -> clear board and counters, done=0, go to REQ (equivalent to IDLE+start).
- Query port: 1-cycle latency. rd_mine/rd_adj reflect rd_idx and the board as of the previous edge.
  - rd_idx >= ROWS*COLS -> rd_mine=0, rd_adj=0.
  - Neighbours are derived from row=rd_idx/COLS, col=rd_idx%COLS. No wrap: column 0 has no left neighbours, column COLS-1 has no right neighbours, and the top/bottom rows are clipped.
  - The cell itself is excluded from rd_adj. rd_adj range 0..8.
  - Query is valid in every state; during REQ it sees the partial board.

Decomposition:
- Shared package minesweeper_pkg:
  - ROWS, COLS, CELLS=ROWS*COLS, MINES, IDX_W
  - placer state enum (IDLE, REQ, DONE)
- Sub-module mine_neighbour_count:
  - Combinational: board bitmap + row/col in, 4-bit adjacent count out.
  - The game-logic reveal path will reuse it.

Test Plan:
- Reset, start, feed idx 0..8 one per cycle -> done=1 on cycle after 9th accept, mines_placed=9, reject_count=0, idx_req=0; rd_idx=8 -> rd_mine=1 next cycle.
- Feed 5,5,5,7 -> mines_placed=2, reject_count=2, board bits 5 and 7 only set.
- Feed 81 then 200 -> both rejected, reject_count=2, mines_placed=0, still REQ.
- Place {0,1,9,10,18,27,36,45,54}, then query each cell below -> each value holds one cycle after its query:
  - rd_idx=0 -> mine=1, adj=3
  - rd_idx=11 -> mine=0, adj=2
  - rd_idx=19 -> adj=4
  - rd_idx=17 -> adj=0 (no wrap to 9/18)
  - rd_idx=80 -> adj=0
  - rd_idx=81 -> mine=0, adj=0
- After 4 accepts assert reset=0 between edges -> outputs clear immediately (idx_req=0, mines_placed=0, board clear); release, start -> fresh placement from 0.
- Pulse start during REQ -> counts unchanged. Pulse start in DONE -> board cleared, done=0, idx_req=1, mines_placed=0.
